// File: rtl/axi_full_mst_burst.sv
`default_nettype none
// ============================================================================
//  Module   : axi_full_mst_burst
//  Purpose  : AXI4 single-outstanding INCR burst initiator driven by a simple
//             command port plus write/read data streams.
//             Optional watchdog: define AXI_FULL_MST_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_full_mst_burst #(
  parameter int DW     = 128,
  parameter int AW     = 32,
  parameter int IDW    = 4,
  parameter int ID     = 0,
  parameter int TO_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AW-1:0]     CMD_ADDR,
  input  logic [7:0]        CMD_LEN,
  input  logic              WD_VALID,
  output logic              WD_READY,
  input  logic [DW-1:0]     WD_DATA,
  input  logic [DW/8-1:0]   WD_STRB,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [DW-1:0]     RD_DATA,
  output logic              RD_LAST,
  output logic              DONE_VALID,
  output logic [1:0]        DONE_RESP,
  output logic [IDW-1:0]    MEM_AWID,
  output logic [AW-1:0]     MEM_AWADDR,
  output logic [7:0]        MEM_AWLEN,
  output logic [2:0]        MEM_AWSIZE,
  output logic [1:0]        MEM_AWBURST,
  output logic              MEM_AWVALID,
  input  logic              MEM_AWREADY,
  output logic [DW-1:0]     MEM_WDATA,
  output logic [DW/8-1:0]   MEM_WSTRB,
  output logic              MEM_WLAST,
  output logic              MEM_WVALID,
  input  logic              MEM_WREADY,
  input  logic [IDW-1:0]    MEM_BID,
  input  logic [1:0]        MEM_BRESP,
  input  logic              MEM_BVALID,
  output logic              MEM_BREADY,
  output logic [IDW-1:0]    MEM_ARID,
  output logic [AW-1:0]     MEM_ARADDR,
  output logic [7:0]        MEM_ARLEN,
  output logic [2:0]        MEM_ARSIZE,
  output logic [1:0]        MEM_ARBURST,
  output logic              MEM_ARVALID,
  input  logic              MEM_ARREADY,
  input  logic [IDW-1:0]    MEM_RID,
  input  logic [DW-1:0]     MEM_RDATA,
  input  logic [1:0]        MEM_RRESP,
  input  logic              MEM_RLAST,
  input  logic              MEM_RVALID,
  output logic              MEM_RREADY
);

  localparam int             c_SIZE = $clog2(DW/8);
  localparam logic [IDW-1:0] c_ID   = IDW'(ID);
  localparam logic [AW-1:0]  c_MASK = ~((AW'(1) << c_SIZE) - AW'(1));

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [1:0]    r_resp;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_last_cnt, w_to;
  logic [1:0] w_r_err, w_b_err;

  function automatic logic [1:0] f_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_last_cnt = (r_cnt == r_len);
  assign w_aw_hs    = (r_state == S_AW) && MEM_AWREADY;
  assign w_w_hs     = (r_state == S_W)  && WD_VALID && MEM_WREADY;
  assign w_b_hs     = (r_state == S_B)  && MEM_BVALID;
  assign w_ar_hs    = (r_state == S_AR) && MEM_ARREADY;
  assign w_r_hs     = (r_state == S_R)  && MEM_RVALID && RD_READY;

  // Beat-count disagreement with RLAST, or a foreign ID, is a slave error
  assign w_r_err = ((MEM_RID != c_ID) || (MEM_RLAST != w_last_cnt)) ? 2'b10 : 2'b00;
  assign w_b_err = (MEM_BID != c_ID) ? 2'b10 : 2'b00;

`ifdef AXI_FULL_MST_TIMEOUT_EN
  localparam int c_TOW = $clog2(TO_CYC + 1);
  logic [c_TOW-1:0] r_wdog;
  logic             w_busy, w_any_hs;

  assign w_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
  assign w_to     = w_busy && !w_any_hs && (r_wdog == c_TOW'(TO_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wdog <= '0;
    end else if (!w_busy || w_any_hs || w_to) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + c_TOW'(1);
    end
  end
`else
  // Without the watchdog the block waits indefinitely
  assign w_to = (TO_CYC < 0);
`endif

  always_comb begin
    w_next      = r_state;
    CMD_READY   = 1'b0;
    MEM_AWVALID = 1'b0;
    MEM_WVALID  = 1'b0;
    WD_READY    = 1'b0;
    MEM_WLAST   = 1'b0;
    MEM_BREADY  = 1'b0;
    MEM_ARVALID = 1'b0;
    MEM_RREADY  = 1'b0;
    RD_VALID    = 1'b0;
    RD_LAST     = 1'b0;
    DONE_VALID  = 1'b0;
    case (r_state)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) w_next = CMD_WRITE ? S_AW : S_AR;
      end
      S_AW: begin
        MEM_AWVALID = 1'b1;
        if (w_aw_hs) w_next = S_W;
      end
      S_W: begin
        MEM_WVALID = WD_VALID;
        WD_READY   = MEM_WREADY;
        MEM_WLAST  = w_last_cnt;
        if (w_w_hs && w_last_cnt) w_next = S_B;
      end
      S_B: begin
        MEM_BREADY = 1'b1;
        if (w_b_hs) w_next = S_DONE;
      end
      S_AR: begin
        MEM_ARVALID = 1'b1;
        if (w_ar_hs) w_next = S_R;
      end
      S_R: begin
        MEM_RREADY = RD_READY;
        RD_VALID   = MEM_RVALID;
        RD_LAST    = MEM_RLAST;
        if (w_r_hs && MEM_RLAST) w_next = S_DONE;
      end
      S_DONE: begin
        DONE_VALID = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_to) w_next = S_DONE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_resp  <= 2'b00;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (CMD_VALID) begin
            r_addr <= CMD_ADDR & c_MASK;
            r_len  <= CMD_LEN;
            r_cnt  <= '0;
            r_resp <= 2'b00;
          end
        end
        S_W: begin
          if (w_w_hs) r_cnt <= w_last_cnt ? 8'd0 : r_cnt + 8'd1;
        end
        S_B: begin
          if (w_b_hs) r_resp <= f_max(MEM_BRESP, w_b_err);
        end
        S_R: begin
          // Keep counting past len so a missing RLAST drains to the real end
          if (w_r_hs) begin
            r_cnt  <= r_cnt + 8'd1;
            r_resp <= f_max(r_resp, f_max(MEM_RRESP, w_r_err));
          end
        end
        S_DONE: r_cnt <= '0;
        default: ;
      endcase
      if (w_to) r_resp <= 2'b11;
    end
  end

  assign DONE_RESP   = r_resp;
  assign MEM_AWID    = c_ID;
  assign MEM_AWADDR  = r_addr;
  assign MEM_AWLEN   = r_len;
  assign MEM_AWSIZE  = 3'(c_SIZE);
  assign MEM_AWBURST = 2'b01;
  assign MEM_ARID    = c_ID;
  assign MEM_ARADDR  = r_addr;
  assign MEM_ARLEN   = r_len;
  assign MEM_ARSIZE  = 3'(c_SIZE);
  assign MEM_ARBURST = 2'b01;
  assign MEM_WDATA   = WD_DATA;
  assign MEM_WSTRB   = WD_STRB;
  assign RD_DATA     = MEM_RDATA;

endmodule
`default_nettype wire

// File: tb/tb_axi_full_mst_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_full_mst_burst
//  Purpose  : Self-checking bench for axi_full_mst_burst with a bench-side
//             memory slave and a beat scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_full_mst_burst;
  localparam int DW  = 128;
  localparam int AW  = 32;
  localparam int IDW = 4;
  localparam int ID  = 5;
  localparam int TO  = 16;

  logic CLK, RST;
  logic CMD_VALID, CMD_READY, CMD_WRITE;
  logic [AW-1:0] CMD_ADDR;
  logic [7:0] CMD_LEN;
  logic WD_VALID, WD_READY;
  logic [DW-1:0] WD_DATA;
  logic [DW/8-1:0] WD_STRB;
  logic RD_VALID, RD_READY, RD_LAST;
  logic [DW-1:0] RD_DATA;
  logic DONE_VALID;
  logic [1:0] DONE_RESP;
  logic [IDW-1:0] MEM_AWID, MEM_ARID, MEM_BID, MEM_RID;
  logic [AW-1:0] MEM_AWADDR, MEM_ARADDR;
  logic [7:0] MEM_AWLEN, MEM_ARLEN;
  logic [2:0] MEM_AWSIZE, MEM_ARSIZE;
  logic [1:0] MEM_AWBURST, MEM_ARBURST, MEM_BRESP, MEM_RRESP;
  logic MEM_AWVALID, MEM_AWREADY, MEM_WLAST, MEM_WVALID, MEM_WREADY;
  logic MEM_BVALID, MEM_BREADY, MEM_ARVALID, MEM_ARREADY;
  logic MEM_RLAST, MEM_RVALID, MEM_RREADY;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA;
  logic [DW/8-1:0] MEM_WSTRB;

  axi_full_mst_burst #(.DW(DW), .AW(AW), .IDW(IDW), .ID(ID), .TO_CYC(TO)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA), .WD_STRB(WD_STRB),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
    .DONE_VALID(DONE_VALID), .DONE_RESP(DONE_RESP),
    .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
    .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID),
    .MEM_AWREADY(MEM_AWREADY),
    .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
    .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
    .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
    .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID),
    .MEM_ARREADY(MEM_ARREADY),
    .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
    .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [7:0]   len;
    int           nbeats;    // read beats the slave returns
    int           err_beat;  // read beat carrying resp (-1 = none)
    logic [1:0]   resp;      // BRESP for writes, RRESP on err_beat for reads
    logic [3:0]   xid;       // BID/RID returned by the slave
    bit           bub;       // bubbles on stream and slave side
    logic [31:0]  exp_addr;
    logic [1:0]   exp_resp;
    logic [127:0] dbase;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic         l;
    logic [15:0]  s;
  } beat_t;

  vec_t  tv[11];
  beat_t exp_q[$];
  logic [127:0] mem [logic [31:0]];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(bit wr, logic [31:0] a, logic [7:0] l, int nb, int eb,
                              logic [1:0] rs, logic [3:0] x, bit bub, logic [31:0] ea,
                              logic [1:0] er, logic [127:0] db);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.nbeats = nb; v.err_beat = eb; v.resp = rs;
    v.xid = x; v.bub = bub; v.exp_addr = ea; v.exp_resp = er; v.dbase = db;
    return v;
  endfunction

  function automatic logic [127:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {4{a}};
  endfunction

  task automatic issue(input vec_t v);
    chk("cmd_ready_idle", CMD_READY, 1);
    CMD_VALID = 1; CMD_WRITE = v.wr; CMD_ADDR = v.addr; CMD_LEN = v.len;
    tick();
    CMD_VALID = 0; CMD_ADDR = '1;
    #1;
    chk("cmd_ready_busy", CMD_READY, 0);
  endtask

  task automatic do_write(input vec_t v);
    int got, pres, cyc;
    beat_t e;
    chk("awvalid", MEM_AWVALID, 1);
    chk("awaddr", MEM_AWADDR, v.exp_addr);
    chk("awlen", MEM_AWLEN, v.len);
    chk("awsize", MEM_AWSIZE, 4);
    chk("awburst", MEM_AWBURST, 1);
    chk("awid", MEM_AWID, ID);
    tick();
    chk("awaddr_hold", MEM_AWADDR, v.exp_addr);
    MEM_AWREADY = 1;
    tick();
    MEM_AWREADY = 0;
    got = 0; pres = 0; cyc = 0;
    while (got <= int'(v.len) && cyc < 64) begin
      if (pres == got) begin
        if (!v.bub || (cyc % 2 == 0)) begin
          WD_VALID = 1;
          WD_DATA  = v.dbase + 128'(got);
          WD_STRB  = v.bub ? (16'hA5A5 ^ 16'(got)) : 16'hFFFF;
          exp_q.push_back('{WD_DATA, (got == int'(v.len)), WD_STRB});
          pres++;
        end else begin
          WD_VALID = 0;
        end
      end
      MEM_WREADY = v.bub ? (cyc % 3 != 1) : 1'b1;
      #1;
      chk("wvalid_pass", MEM_WVALID, WD_VALID);
      chk("wd_ready_pass", WD_READY, MEM_WREADY);
      if (WD_VALID && MEM_WREADY) begin
        if (exp_q.size() == 0) begin
          chk("w_sb_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wdata", MEM_WDATA, e.d);
          chk("wlast", MEM_WLAST, e.l);
          chk("wstrb", MEM_WSTRB, e.s);
        end
        mem[v.exp_addr + 32'(got * 16)] = MEM_WDATA;
        got++;
      end
      tick();
      cyc++;
    end
    WD_VALID = 0; MEM_WREADY = 0;
    chk("w_timeout", cyc < 64, 1);
    if (!v.bub) chk("w_cycles", cyc, int'(v.len) + 1);
    #1;
    chk("wvalid_after", MEM_WVALID, 0);
    chk("bready", MEM_BREADY, 1);
    MEM_BVALID = 1; MEM_BRESP = v.resp; MEM_BID = v.xid;
    tick();
    MEM_BVALID = 0; MEM_BRESP = 0; MEM_BID = 0;
  endtask

  task automatic do_read(input vec_t v);
    int i, pushed, cyc;
    beat_t e;
    chk("arvalid", MEM_ARVALID, 1);
    chk("awvalid_rd", MEM_AWVALID, 0);
    chk("araddr", MEM_ARADDR, v.exp_addr);
    chk("arlen", MEM_ARLEN, v.len);
    chk("arsize", MEM_ARSIZE, 4);
    chk("arburst", MEM_ARBURST, 1);
    chk("arid", MEM_ARID, ID);
    MEM_ARREADY = 1;
    tick();
    MEM_ARREADY = 0;
    i = 0; pushed = 0; cyc = 0;
    while (i < v.nbeats && cyc < 64) begin
      RD_READY   = v.bub ? (cyc % 2 == 0) : 1'b1;
      MEM_RVALID = 1;
      MEM_RDATA  = rd_mem(v.exp_addr + 32'(i * 16));
      MEM_RLAST  = (i == v.nbeats - 1);
      MEM_RRESP  = (i == v.err_beat) ? v.resp : 2'b00;
      MEM_RID    = v.xid;
      if (pushed == i) begin
        exp_q.push_back('{MEM_RDATA, MEM_RLAST, 16'h0});
        pushed++;
      end
      #1;
      chk("rready_pass", MEM_RREADY, RD_READY);
      chk("rd_valid", RD_VALID, 1);
      if (RD_READY) begin
        if (exp_q.size() == 0) begin
          chk("r_sb_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", RD_DATA, e.d);
          chk("rd_last", RD_LAST, e.l);
        end
        i++;
      end
      tick();
      cyc++;
    end
    MEM_RVALID = 0; MEM_RLAST = 0; MEM_RRESP = 0; RD_READY = 0;
    chk("r_timeout", cyc < 64, 1);
  endtask

  task automatic finish_cmd(input vec_t v);
    #1;
    chk("done_valid", DONE_VALID, 1);
    chk("done_resp", DONE_RESP, v.exp_resp);
    chk("cmd_ready_done", CMD_READY, 0);
    tick();
    chk("done_pulse_end", DONE_VALID, 0);
    chk("cmd_ready_back", CMD_READY, 1);
    chk("sb_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, seen;
    RST = 1; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_LEN = 0;
    WD_VALID = 0; WD_DATA = 0; WD_STRB = 0; RD_READY = 0;
    MEM_AWREADY = 0; MEM_WREADY = 0; MEM_BID = 0; MEM_BRESP = 0; MEM_BVALID = 0;
    MEM_ARREADY = 0; MEM_RID = 0; MEM_RDATA = 0; MEM_RRESP = 0; MEM_RLAST = 0; MEM_RVALID = 0;

    tv[0]  = mk(1, 32'h8000_0010, 8'd3, 0, -1, 2'b00, 4'd5, 0, 32'h8000_0010, 2'b00, 128'h0);
    tv[1]  = mk(0, 32'h8000_0010, 8'd3, 4, -1, 2'b00, 4'd5, 1, 32'h8000_0010, 2'b00, 128'h0);
    tv[2]  = mk(1, 32'h8000_0017, 8'd1, 0, -1, 2'b00, 4'd5, 1, 32'h8000_0010, 2'b00, 128'h100);
    tv[3]  = mk(0, 32'h8000_0010, 8'd3, 2, -1, 2'b00, 4'd5, 0, 32'h8000_0010, 2'b10, 128'h0);
    tv[4]  = mk(0, 32'h8000_0010, 8'd3, 4,  2, 2'b10, 4'd5, 0, 32'h8000_0010, 2'b10, 128'h0);
    tv[5]  = mk(0, 32'h8000_0020, 8'd0, 1, -1, 2'b00, 4'd5, 1, 32'h8000_0020, 2'b00, 128'h0);
    tv[6]  = mk(1, 32'h8000_0400, 8'd7, 0, -1, 2'b01, 4'd5, 0, 32'h8000_0400, 2'b01, 128'hAB00);
    tv[7]  = mk(1, 32'h8000_0000, 8'd0, 0, -1, 2'b00, 4'd3, 0, 32'h8000_0000, 2'b10, 128'hC0);
    tv[8]  = mk(0, 32'h8000_0400, 8'd1, 3, -1, 2'b00, 4'd5, 0, 32'h8000_0400, 2'b10, 128'h0);
    tv[9]  = mk(0, 32'h8000_0400, 8'd2, 3, -1, 2'b00, 4'd3, 0, 32'h8000_0400, 2'b10, 128'h0);
    tv[10] = mk(0, 32'h8000_0400, 8'd7, 8, -1, 2'b00, 4'd5, 1, 32'h8000_0400, 2'b00, 128'h0);

    repeat (3) tick();
    chk("rst_cmd_ready", CMD_READY, 1);
    chk("rst_awvalid", MEM_AWVALID, 0);
    chk("rst_wvalid", MEM_WVALID, 0);
    chk("rst_bready", MEM_BREADY, 0);
    chk("rst_arvalid", MEM_ARVALID, 0);
    chk("rst_rready", MEM_RREADY, 0);
    chk("rst_rd_valid", RD_VALID, 0);
    chk("rst_wd_ready", WD_READY, 0);
    chk("rst_done_valid", DONE_VALID, 0);
    chk("rst_done_resp", DONE_RESP, 0);
    RST = 0;
    tick();

    for (int k = 0; k < 11; k++) begin
      issue(tv[k]);
      if (tv[k].wr) do_write(tv[k]);
      else          do_read(tv[k]);
      finish_cmd(tv[k]);
    end

    // Reset during write beat 1
    issue(tv[0]);
    MEM_AWREADY = 1;
    tick();
    MEM_AWREADY = 0;
    WD_VALID = 1; WD_DATA = 128'h11; WD_STRB = '1; MEM_WREADY = 1;
    tick();
    WD_DATA = 128'h12;
    #1;
    chk("mid_wvalid", MEM_WVALID, 1);
    RST = 1;
    #1;
    chk("rst_mid_wvalid", MEM_WVALID, 0);
    chk("rst_mid_cmd_ready", CMD_READY, 1);
    seen = 0;
    tick();
    RST = 0;
    WD_VALID = 0; MEM_WREADY = 0;
    for (int c = 0; c < 4; c++) begin
      if (DONE_VALID) seen++;
      tick();
    end
    chk("rst_no_done", seen, 0);
    chk("rst_idle_ready", CMD_READY, 1);

`ifdef AXI_FULL_MST_TIMEOUT_EN
    issue(tv[0]);
    n = 0;
    while (!DONE_VALID && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_resp", DONE_RESP, 2'b11);
    chk("to_awvalid", MEM_AWVALID, 0);
    tick();
    chk("to_cmd_ready", CMD_READY, 1);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
